// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator sequencer.
//   calc_state_t  sequencer state encoding (STATE_W bits)
//   OP_DIV_BIT    position of the divide opcode in the one-hot op vector
//   calc_digits   number of seven-segment hex digits for given W/RW
package calc_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_HALT  = 3'd4
    } calc_state_t;

    localparam int OP_DIV_BIT = 0;

    // {A, B, result} displayed as hex nibbles
    function automatic int calc_digits(input int w, input int rw);
        return (2 * w + rw) / 4;
    endfunction

endpackage

// File: rtl/calc_btn_edge.sv
// calc_btn_edge: rising-edge detector over NOP button lines with a priority
// pick; the highest newly pressed button wins, the others are dropped.
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   btn   in   NOP  debounced button levels
//   pick  out  NOP  registered one-hot request (or zero), valid one cycle
module calc_btn_edge
    import calc_pkg::*;
#(
    parameter int NOP = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NOP-1:0] btn,
    output logic [NOP-1:0] pick
);

    logic [NOP-1:0] btn_q;
    logic [NOP-1:0] req;
    logic [NOP-1:0] pick_d;

    assign req = btn & ~btn_q;

    // Ascending scan so the highest set bit overwrites any lower one.
    always_comb begin
        pick_d = '0;
        for (int i = 0; i < NOP; i++) begin
            if (req[i]) begin
                pick_d    = '0;
                pick_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= '0;
            pick  <= '0;
        end else begin
            btn_q <= btn;
            pick  <= pick_d;
        end
    end

endmodule

// File: rtl/calc_ctrl_param.sv
// calc_ctrl_param: calculator sequencer between board switches/buttons and a
// multi-cycle ALU. Latches operands and a one-hot opcode on a button press,
// issues one ALU operation, registers its result and drives the display.
//   clk, rst          clock, synchronous active-high reset
//   sw_i              {A, B} operand switches
//   btn_i             one-hot op request buttons (bit OP_DIV_BIT = divide)
//   acc_mode_i        take A from result_o[W-1:0] instead of the switches
//   clr_i             leave HALT
//   alu_start_o/op_o/a_o/b_o   ALU request side
//   alu_busy_i/res_i           ALU completion side
//   result_o          last good result
//   seg_num_o/en_o    {A, B, result} hex digits and their enables
//   err_div0_o/tmo_o  halt reasons
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a request, operand digits shown
// S_ISSUE | one-cycle ALU start pulse
// S_WAIT  | waiting for busy 1->0, bounded by TIMEOUT cycles
// S_DONE  | result shown; accepts the next request like IDLE
// S_HALT  | divide-by-zero or timeout, display dark until clr_i
module calc_ctrl_param
    import calc_pkg::*;
#(
    parameter int W       = 4,
    parameter int RW      = 2 * W,
    parameter int NOP     = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2*W-1:0]                    sw_i,
    input  logic [NOP-1:0]                    btn_i,
    input  logic                              acc_mode_i,
    input  logic                              clr_i,
    output logic                              alu_start_o,
    output logic [NOP-1:0]                    alu_op_o,
    output logic [W-1:0]                      alu_a_o,
    output logic [W-1:0]                      alu_b_o,
    input  logic                              alu_busy_i,
    input  logic [RW-1:0]                     alu_res_i,
    output logic [RW-1:0]                     result_o,
    output logic [2*W+RW-1:0]                 seg_num_o,
    output logic [calc_digits(W, RW)-1:0]     seg_en_o,
    output logic                              err_div0_o,
    output logic                              err_tmo_o
);

    localparam int DIGITS = calc_digits(W, RW);
    localparam int TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [DIGITS-1:0] MASK_OPS = {{(2 * W / 4){1'b1}}, {(RW / 4){1'b0}}};
    localparam logic [DIGITS-1:0] MASK_ALL = '1;
    localparam logic [DIGITS-1:0] MASK_OFF = '0;
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

    calc_state_t    state;
    logic [NOP-1:0] req;
    logic           busy_q;
    logic [TW-1:0]  tmo_cnt;
    logic [W-1:0]   sw_a;
    logic [W-1:0]   sw_b;

    assign sw_a = sw_i[2*W-1:W];
    assign sw_b = sw_i[W-1:0];

    calc_btn_edge #(.NOP(NOP)) u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_i),
        .pick (req)
    );

    assign seg_num_o = {alu_a_o, alu_b_o, result_o};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy_q      <= 1'b0;
            tmo_cnt     <= '0;
            alu_start_o <= 1'b0;
            alu_op_o    <= '0;
            alu_a_o     <= '0;
            alu_b_o     <= '0;
            result_o    <= '0;
            seg_en_o    <= '0;
            err_div0_o  <= 1'b0;
            err_tmo_o   <= 1'b0;
        end else begin
            busy_q      <= alu_busy_i;
            alu_start_o <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    seg_en_o <= (state == S_DONE) ? MASK_ALL : MASK_OPS;
                    if (|req) begin
                        if (req[OP_DIV_BIT] && (sw_b == '0)) begin
                            state      <= S_HALT;
                            err_div0_o <= 1'b1;
                            alu_op_o   <= '0;
                            seg_en_o   <= MASK_OFF;
                        end else begin
                            state       <= S_ISSUE;
                            alu_start_o <= 1'b1;
                            alu_op_o    <= req;
                            alu_a_o     <= acc_mode_i ? result_o[W-1:0] : sw_a;
                            alu_b_o     <= sw_b;
                            seg_en_o    <= MASK_OPS;
                        end
                    end
                end

                S_ISSUE: begin
                    state    <= S_WAIT;
                    tmo_cnt  <= '0;
                    seg_en_o <= MASK_OPS;
                end

                S_WAIT: begin
                    // A completion on the last allowed cycle still counts.
                    if (busy_q && !alu_busy_i) begin
                        state    <= S_DONE;
                        result_o <= alu_res_i;
                        seg_en_o <= MASK_ALL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= S_HALT;
                        err_tmo_o <= 1'b1;
                        alu_op_o  <= '0;
                        seg_en_o  <= MASK_OFF;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                S_HALT: begin
                    alu_op_o <= '0;
                    seg_en_o <= MASK_OFF;
                    if (clr_i) begin
                        state      <= S_IDLE;
                        err_div0_o <= 1'b0;
                        err_tmo_o  <= 1'b0;
                        seg_en_o   <= MASK_OPS;
                    end
                end

                default: begin
                    // Corrupted encoding: park safely, no error reason claimed.
                    state      <= S_HALT;
                    alu_op_o   <= '0;
                    err_div0_o <= 1'b0;
                    err_tmo_o  <= 1'b0;
                    seg_en_o   <= MASK_OFF;
                end
            endcase
        end
    end

endmodule
